// File: rtl/ddr_apb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : ddr_apb_cfg_slave
// Brief    : APB3 completer holding the DDR controller configuration and
//            control registers, with a programmable number of wait states.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk, sys_rst          clock / asynchronous active-high reset
//   ext_psel .. ext_pwdata    APB request from the external initiator
//   ext_prdata, ext_pready,   APB response, registered, valid only in the
//   ext_pslverr               single completion cycle
//   rtl_ready, init_done      status inputs from the controller core
//   ctrl_enable               CTRL[0]
//   soft_rst_pulse            one-cycle pulse after a write of 1 to CTRL[1]
//   ddr_cfg, timing0          static register contents
//   cfg_update                one-cycle pulse after any successful write
// ============================================================================
module ddr_apb_cfg_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0DD4_0001,
  parameter logic [31:0] DDR_CFG_RST = 32'h0003_0000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  ext_psel,
  input  logic                  ext_penable,
  input  logic                  ext_pwr,
  input  logic [ADDR_WIDTH-1:0] ext_paddr,
  input  logic [31:0]           ext_pwdata,
  output logic [31:0]           ext_prdata,
  output logic                  ext_pready,
  output logic                  ext_pslverr,
  input  logic                  rtl_ready,
  input  logic                  init_done,
  output logic                  ctrl_enable,
  output logic                  soft_rst_pulse,
  output logic [31:0]           ddr_cfg,
  output logic [31:0]           timing0,
  output logic                  cfg_update
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETUP  = 2'd1;
  localparam logic [1:0] c_ST_ACCESS = 2'd2;

  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

  localparam logic [ADDR_WIDTH-1:0] c_OFF_CTRL    = ADDR_WIDTH'(32'h000);
  localparam logic [ADDR_WIDTH-1:0] c_OFF_DDR_CFG = ADDR_WIDTH'(32'h004);
  localparam logic [ADDR_WIDTH-1:0] c_OFF_TIMING0 = ADDR_WIDTH'(32'h008);
  localparam logic [ADDR_WIDTH-1:0] c_OFF_STATUS  = ADDR_WIDTH'(32'h00C);
  localparam logic [ADDR_WIDTH-1:0] c_OFF_SCRATCH = ADDR_WIDTH'(32'h010);
  localparam logic [ADDR_WIDTH-1:0] c_OFF_ID      = ADDR_WIDTH'(32'h014);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pwr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_cnt;

  logic [31:0]           r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic                  r_ctrl_enable;
  logic                  r_soft_rst_pulse;
  logic [31:0]           r_ddr_cfg;
  logic [31:0]           r_timing0;
  logic [31:0]           r_scratch;
  logic                  r_cfg_update;

  logic                  w_latch;
  logic                  w_resp;
  logic                  w_commit;

  logic [ADDR_WIDTH-1:0] w_eff_addr;
  logic                  w_eff_wr;
  logic                  w_err;
  logic [31:0]           w_rdata;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        // An access phase without a preceding setup phase is ignored.
        if (ext_psel && !ext_penable) begin
          w_next_state = c_ST_SETUP;
        end
      end
      c_ST_SETUP: begin
        w_next_state = ext_psel ? c_ST_ACCESS : c_ST_IDLE;
      end
      c_ST_ACCESS: begin
        if (r_pready || !ext_psel) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  //   w_latch  : capture request and load the wait counter
  //   w_resp   : the next cycle is the completion cycle
  //   w_commit : this is the completion cycle of an error-free write
  // --------------------------------------------------------------------------
  always_comb begin
    w_latch  = 1'b0;
    w_resp   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      c_ST_SETUP: begin
        w_latch = ext_psel;
        w_resp  = ext_psel && (c_WAIT == 4'd0);
      end
      c_ST_ACCESS: begin
        // Counter reaches 1 in the last wait cycle; pready is registered.
        w_resp   = ext_psel && !r_pready && (r_cnt == 4'd1);
        w_commit = r_pready && r_pwr && !r_pslverr;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Decode. With no wait states the response is prepared in SETUP, before the
  // latch holds the request, so the live bus is used there.
  // --------------------------------------------------------------------------
  assign w_eff_addr = (r_state == c_ST_SETUP) ? ext_paddr : r_addr;
  assign w_eff_wr   = (r_state == c_ST_SETUP) ? ext_pwr   : r_pwr;

  always_comb begin
    w_err = 1'b0;
    if (w_eff_addr[1:0] != 2'b00) begin
      w_err = 1'b1;
    end
    if (w_eff_addr > c_OFF_ID) begin
      w_err = 1'b1;
    end
    if (w_eff_wr && ((w_eff_addr == c_OFF_STATUS) || (w_eff_addr == c_OFF_ID))) begin
      w_err = 1'b1;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_eff_addr)
      c_OFF_CTRL:    w_rdata = {31'd0, r_ctrl_enable};
      c_OFF_DDR_CFG: w_rdata = r_ddr_cfg;
      c_OFF_TIMING0: w_rdata = r_timing0;
      c_OFF_STATUS:  w_rdata = {30'd0, init_done, rtl_ready};
      c_OFF_SCRATCH: w_rdata = r_scratch;
      c_OFF_ID:      w_rdata = ID_VALUE;
      default:       w_rdata = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter and APB response
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_addr    <= '0;
      r_pwr     <= 1'b0;
      r_wdata   <= 32'd0;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'd0;
    end else begin
      if (w_latch) begin
        r_addr  <= ext_paddr;
        r_pwr   <= ext_pwr;
        r_wdata <= ext_pwdata;
        r_cnt   <= c_WAIT;
      end else if ((r_state == c_ST_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_pready  <= w_resp;
      r_pslverr <= w_resp && w_err;
      r_prdata  <= (w_resp && !w_err && !w_eff_wr) ? w_rdata : 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers; written on the edge ending the completion cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ctrl_enable    <= 1'b0;
      r_soft_rst_pulse <= 1'b0;
      r_ddr_cfg        <= DDR_CFG_RST;
      r_timing0        <= 32'd0;
      r_scratch        <= 32'd0;
      r_cfg_update     <= 1'b0;
    end else begin
      r_cfg_update     <= w_commit;
      r_soft_rst_pulse <= w_commit && (r_addr == c_OFF_CTRL) && r_wdata[1];
      if (w_commit) begin
        case (r_addr)
          c_OFF_CTRL:    r_ctrl_enable <= r_wdata[0];
          c_OFF_DDR_CFG: r_ddr_cfg     <= r_wdata;
          c_OFF_TIMING0: r_timing0     <= r_wdata;
          c_OFF_SCRATCH: r_scratch     <= r_wdata;
          default: ;
        endcase
      end
    end
  end

  assign ext_prdata     = r_prdata;
  assign ext_pready     = r_pready;
  assign ext_pslverr    = r_pslverr;
  assign ctrl_enable    = r_ctrl_enable;
  assign soft_rst_pulse = r_soft_rst_pulse;
  assign ddr_cfg        = r_ddr_cfg;
  assign timing0        = r_timing0;
  assign cfg_update     = r_cfg_update;

endmodule
`default_nettype wire

// File: tb/tb_ddr_apb_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_apb_cfg_slave
// Brief    : Directed self-checking bench for ddr_apb_cfg_slave
//            (default parameters, WAIT_STATES = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_apb_cfg_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ext_psel = 1'b0;
  logic        ext_penable = 1'b0;
  logic        ext_pwr = 1'b0;
  logic [9:0]  ext_paddr = '0;
  logic [31:0] ext_pwdata = '0;
  logic [31:0] ext_prdata;
  logic        ext_pready;
  logic        ext_pslverr;
  logic        rtl_ready = 1'b0;
  logic        init_done = 1'b0;
  logic        ctrl_enable;
  logic        soft_rst_pulse;
  logic [31:0] ddr_cfg;
  logic [31:0] timing0;
  logic        cfg_update;

  int vectors = 0;
  int miscompares = 0;

  ddr_apb_cfg_slave dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .ext_psel       (ext_psel),
    .ext_penable    (ext_penable),
    .ext_pwr        (ext_pwr),
    .ext_paddr      (ext_paddr),
    .ext_pwdata     (ext_pwdata),
    .ext_prdata     (ext_prdata),
    .ext_pready     (ext_pready),
    .ext_pslverr    (ext_pslverr),
    .rtl_ready      (rtl_ready),
    .init_done      (init_done),
    .ctrl_enable    (ctrl_enable),
    .soft_rst_pulse (soft_rst_pulse),
    .ddr_cfg        (ddr_cfg),
    .timing0        (timing0),
    .cfg_update     (cfg_update)
  );

  always #5 sys_clk = ~sys_clk;

  // One APB transfer. Returns the ACCESS cycle number in which pready was seen
  // (99 on timeout, -1 if pready showed up in the setup/first access cycle).
  task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int n);
    logic early;
    @(posedge sys_clk); #1;
    ext_psel = 1'b1; ext_penable = 1'b0; ext_pwr = wr; ext_paddr = addr; ext_pwdata = wdata;
    @(posedge sys_clk); #1;
    early = ext_pready;
    ext_penable = 1'b1;
    n = 0; rdata = 32'd0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      n++;
      if (ext_pready) begin
        rdata = ext_prdata;
        err   = ext_pslverr;
        break;
      end
    end
    if (!ext_pready) n = 99;
    if (early) n = -1;
  endtask

  // Advance one cycle, sample the post-completion pulses, release the bus.
  task automatic go_idle(output logic cu, output logic srp);
    @(posedge sys_clk); #1;
    cu  = cfg_update;
    srp = soft_rst_pulse;
    ext_psel = 1'b0; ext_penable = 1'b0; ext_pwr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    vectors++; if (ext_pready !== 1'b0) begin miscompares++; $display("FAIL rst_pready got %b exp 0", ext_pready); end
    vectors++; if (ext_pslverr !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr got %b exp 0", ext_pslverr); end
    vectors++; if (ext_prdata !== 32'd0) begin miscompares++; $display("FAIL rst_prdata got %h exp 0", ext_prdata); end
    vectors++; if (ctrl_enable !== 1'b0) begin miscompares++; $display("FAIL rst_ctrl_enable got %b exp 0", ctrl_enable); end
    vectors++; if (soft_rst_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_soft_rst got %b exp 0", soft_rst_pulse); end
    vectors++; if (ddr_cfg !== 32'h0003_0000) begin miscompares++; $display("FAIL rst_ddr_cfg got %h exp 00030000", ddr_cfg); end
    vectors++; if (timing0 !== 32'd0) begin miscompares++; $display("FAIL rst_timing0 got %h exp 0", timing0); end
    vectors++; if (cfg_update !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_update got %b exp 0", cfg_update); end
    sys_rst = 1'b0;
  endtask

  task automatic test_read_ddr_cfg();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    apb_xfer(1'b0, 10'h004, 32'd0, rd, er, n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL rd_ddrcfg_latency got %0d exp 2", n); end
    vectors++; if (rd !== 32'h0003_0000) begin miscompares++; $display("FAIL rd_ddrcfg_data got %h exp 00030000", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rd_ddrcfg_err got %b exp 0", er); end
    go_idle(cu, srp);
    vectors++; if (cu !== 1'b0) begin miscompares++; $display("FAIL rd_no_cfg_update got %b exp 0", cu); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    apb_xfer(1'b1, 10'h000, 32'h0000_0003, rd, er, n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL ctrl_wr_latency got %0d exp 2", n); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ctrl_wr_err got %b exp 0", er); end
    vectors++; if (ctrl_enable !== 1'b0) begin miscompares++; $display("FAIL ctrl_en_early got %b exp 0", ctrl_enable); end
    go_idle(cu, srp);
    vectors++; if (cu !== 1'b1) begin miscompares++; $display("FAIL ctrl_cfg_update got %b exp 1", cu); end
    vectors++; if (srp !== 1'b1) begin miscompares++; $display("FAIL ctrl_soft_rst got %b exp 1", srp); end
    vectors++; if (ctrl_enable !== 1'b1) begin miscompares++; $display("FAIL ctrl_enable got %b exp 1", ctrl_enable); end
    go_idle(cu, srp);
    vectors++; if (cu !== 1'b0) begin miscompares++; $display("FAIL ctrl_cfg_update_len got %b exp 0", cu); end
    vectors++; if (srp !== 1'b0) begin miscompares++; $display("FAIL ctrl_soft_rst_len got %b exp 0", srp); end
    apb_xfer(1'b0, 10'h000, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL ctrl_readback got %h exp 00000001", rd); end
    go_idle(cu, srp);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    apb_xfer(1'b1, 10'h010, 32'hDEAD_BEEF, rd, er, n);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_err got %b exp 0", er); end
    apb_xfer(1'b0, 10'h010, 32'd0, rd, er, n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_rd1_latency got %0d exp 2", n); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_rd1_data got %h exp deadbeef", rd); end
    apb_xfer(1'b0, 10'h004, 32'd0, rd, er, n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_rd2_latency got %0d exp 2", n); end
    vectors++; if (rd !== 32'h0003_0000) begin miscompares++; $display("FAIL b2b_rd2_data got %h exp 00030000", rd); end
    go_idle(cu, srp);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    logic       wrs[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [9:0] addrs[6] = '{10'h00C, 10'h3F0, 10'h006, 10'h014, 10'h012, 10'h018};
    for (int k = 0; k < 6; k++) begin
      apb_xfer(wrs[k], addrs[k], 32'hFFFF_FFFF, rd, er, n);
      vectors++; if (n !== 2) begin miscompares++; $display("FAIL err%0d_latency got %0d exp 2", k, n); end
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL err%0d_pslverr got %b exp 1", k, er); end
      vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL err%0d_prdata got %h exp 0", k, rd); end
      go_idle(cu, srp);
      vectors++; if (cu !== 1'b0) begin miscompares++; $display("FAIL err%0d_cfg_update got %b exp 0", k, cu); end
    end
    vectors++; if (ddr_cfg !== 32'h0003_0000) begin miscompares++; $display("FAIL err_ddr_cfg got %h exp 00030000", ddr_cfg); end
    vectors++; if (timing0 !== 32'd0) begin miscompares++; $display("FAIL err_timing0 got %h exp 0", timing0); end
    vectors++; if (ctrl_enable !== 1'b1) begin miscompares++; $display("FAIL err_ctrl_enable got %b exp 1", ctrl_enable); end
    apb_xfer(1'b0, 10'h010, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL err_scratch got %h exp deadbeef", rd); end
    go_idle(cu, srp);
  endtask

  task automatic test_status_id();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    rtl_ready = 1'b1; init_done = 1'b0;
    apb_xfer(1'b0, 10'h00C, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'h0000_0001) begin miscompares++; $display("FAIL status_a got %h exp 00000001", rd); end
    go_idle(cu, srp);
    rtl_ready = 1'b0; init_done = 1'b1;
    apb_xfer(1'b0, 10'h00C, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'h0000_0002) begin miscompares++; $display("FAIL status_b got %h exp 00000002", rd); end
    go_idle(cu, srp);
    apb_xfer(1'b0, 10'h014, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'h0DD4_0001) begin miscompares++; $display("FAIL id got %h exp 0dd40001", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL id_err got %b exp 0", er); end
    go_idle(cu, srp);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int n; logic cu, srp; logic seen;
    @(posedge sys_clk); #1;
    ext_psel = 1'b1; ext_penable = 1'b0; ext_pwr = 1'b1; ext_paddr = 10'h008; ext_pwdata = 32'h1234_5678;
    @(posedge sys_clk); #1;
    ext_penable = 1'b1;
    @(posedge sys_clk); #1;
    vectors++; if (ext_pready !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre_pready got %b exp 0", ext_pready); end
    sys_rst = 1'b1;
    #1;
    vectors++; if (ctrl_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_enable got %b exp 0", ctrl_enable); end
    @(posedge sys_clk); #1;
    ext_psel = 1'b0; ext_penable = 1'b0; ext_pwr = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      if (ext_pready || cfg_update) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_pready got %b exp 0", seen); end
    vectors++; if (timing0 !== 32'd0) begin miscompares++; $display("FAIL rstmid_timing0 got %h exp 0", timing0); end
    apb_xfer(1'b1, 10'h008, 32'h1234_5678, rd, er, n);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rstmid_rewr_err got %b exp 0", er); end
    go_idle(cu, srp);
    vectors++; if (timing0 !== 32'h1234_5678) begin miscompares++; $display("FAIL rstmid_rewr got %h exp 12345678", timing0); end
  endtask

  task automatic test_abort();
    logic seen;
    @(posedge sys_clk); #1;
    ext_psel = 1'b1; ext_penable = 1'b0; ext_pwr = 1'b1; ext_paddr = 10'h008; ext_pwdata = 32'hA5A5_A5A5;
    @(posedge sys_clk); #1;
    ext_penable = 1'b1;
    @(posedge sys_clk); #1;
    ext_psel = 1'b0; ext_penable = 1'b0; ext_pwr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      if (ext_pready || cfg_update) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_pready got %b exp 0", seen); end
    vectors++; if (timing0 !== 32'h1234_5678) begin miscompares++; $display("FAIL abort_timing0 got %h exp 12345678", timing0); end
  endtask

  task automatic test_latch_ignore();
    logic [31:0] rd; logic er; int n; logic cu, srp;
    @(posedge sys_clk); #1;
    ext_psel = 1'b1; ext_penable = 1'b0; ext_pwr = 1'b1; ext_paddr = 10'h010; ext_pwdata = 32'h1111_1111;
    @(posedge sys_clk); #1;
    ext_penable = 1'b1;
    @(posedge sys_clk); #1;
    ext_paddr = 10'h008; ext_pwdata = 32'h9999_9999; ext_pwr = 1'b0;
    n = 99;
    for (int i = 0; i < 20; i++) begin
      if (ext_pready) begin n = i; break; end
      @(posedge sys_clk); #1;
    end
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL latch_latency got %0d exp 1", n); end
    go_idle(cu, srp);
    vectors++; if (cu !== 1'b1) begin miscompares++; $display("FAIL latch_cfg_update got %b exp 1", cu); end
    vectors++; if (timing0 !== 32'h1234_5678) begin miscompares++; $display("FAIL latch_timing0 got %h exp 12345678", timing0); end
    apb_xfer(1'b0, 10'h010, 32'd0, rd, er, n);
    vectors++; if (rd !== 32'h1111_1111) begin miscompares++; $display("FAIL latch_scratch got %h exp 11111111", rd); end
    go_idle(cu, srp);
  endtask

  initial begin
    test_reset();
    test_read_ddr_cfg();
    test_ctrl();
    test_back_to_back();
    test_errors();
    test_status_id();
    test_reset_mid();
    test_abort();
    test_latch_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
